// File: rtl/code_converter_sweeper_if.sv
// code_converter_sweeper_if: converter pins, sweep control and result signals of the sweeper.
interface code_converter_sweeper_if;
  logic       start;
  logic       abort;
  logic       a, b, c, d;
  logic       x, y, z, w;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_cnt;
  logic       first_err_valid;
  logic [3:0] first_err_code;
  modport master (
    input  start, abort, x, y, z, w,
    output a, b, c, d, busy, done, pass, err_cnt, first_err_valid, first_err_code
  );
  modport slave (
    output start, abort, x, y, z, w,
    input  a, b, c, d, busy, done, pass, err_cnt, first_err_valid, first_err_code
  );
endinterface

// File: rtl/code_converter_sweeper.sv
// code_converter_sweeper: sweeps codes 0..LAST_CODE through an excess-3 converter and checks code+3.
module code_converter_sweeper #(
  parameter int         SETTLE    = 2,
  parameter logic [3:0] LAST_CODE = 4'd9
) (
  input logic                          clk,
  input logic                          rst_n,
  code_converter_sweeper_if.master     bus
);
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);
  state_t     r_state, w_next;
  logic [3:0] r_code, r_settle, r_fec;
  logic [4:0] r_err_cnt;
  logic       r_pass, r_fev;
  logic       w_go, w_busy, w_mis;
  assign w_go   = bus.start && !bus.abort;
  assign w_busy = (r_state == DRIVE) || (r_state == SAMPLE);
  // an abort in SAMPLE suppresses that cycle's comparison
  assign w_mis  = (r_state == SAMPLE) && !bus.abort && ({bus.x, bus.y, bus.z, bus.w} != r_code + 4'd3);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state == IDLE   ? (w_go ? DRIVE : IDLE) :
             r_state == DONE   ? IDLE :
             bus.abort         ? IDLE :
             r_state == DRIVE  ? (r_settle == SETTLE_M1 ? SAMPLE : DRIVE) :
                                 (r_code == LAST_CODE ? DONE : DRIVE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_code    <= '0;
      r_settle  <= '0;
      r_err_cnt <= '0;
      r_fev     <= 1'b0;
      r_fec     <= '0;
      r_pass    <= 1'b0;
    end else begin
      if (r_state == IDLE && w_go) begin
        r_code    <= '0;
        r_settle  <= '0;
        r_err_cnt <= '0;
        r_fev     <= 1'b0;
        r_fec     <= '0;
        r_pass    <= 1'b0;
      end
      if (r_state == DRIVE) r_settle <= r_settle + 4'd1;
      if (r_state == SAMPLE && w_next == DRIVE) begin
        r_code   <= r_code + 4'd1;
        r_settle <= '0;
      end
      if (w_mis) begin
        r_err_cnt <= r_err_cnt + 5'd1;
        if (!r_fev) begin
          r_fev <= 1'b1;
          r_fec <= r_code;
        end
      end
      if (w_next == DONE) r_pass <= (r_err_cnt == 5'd0) && !w_mis;
      if (w_busy && bus.abort) r_pass <= 1'b0;
    end
  always_comb begin
    bus.busy                       = w_busy;
    bus.done                       = r_state == DONE;
    {bus.a, bus.b, bus.c, bus.d}   = w_busy ? r_code : 4'd0;
    bus.pass                       = r_pass;
    bus.err_cnt                    = r_err_cnt;
    bus.first_err_valid            = r_fev;
    bus.first_err_code             = r_fec;
  end
endmodule

// File: tb/tb_code_converter_sweeper.sv
// tb_code_converter_sweeper: faulty-converter models, table and random sweeps, abort/reset corners.
module tb_code_converter_sweeper;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  code_converter_sweeper_if b0(), b1();
  code_converter_sweeper u0 (.clk(clk), .rst_n(rst_n), .bus(b0.master));
  code_converter_sweeper #(.SETTLE(1), .LAST_CODE(4'd15)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.master));
  logic       sel = 0, start_v = 0, abort_v = 0;
  logic [3:0] s0 = 0, s1 = 0;
  int         fc = 16;
  logic [3:0] c0, c1;
  assign b0.start = start_v && !sel;
  assign b0.abort = abort_v && !sel;
  assign b1.start = start_v && sel;
  assign b1.abort = abort_v && sel;
  assign c0 = {b0.a, b0.b, b0.c, b0.d};
  assign c1 = {b1.a, b1.b, b1.c, b1.d};
  // converter: correct excess-3, then stuck-at-0 mask, stuck-at-1 mask, and an LSB flip on code fc
  assign {b0.x, b0.y, b0.z, b0.w} = ((c0 + 4'd3) & ~s0 | s1) ^ {3'b0, 32'(c0) == fc};
  assign {b1.x, b1.y, b1.z, b1.w} = ((c1 + 4'd3) & ~s0 | s1) ^ {3'b0, 32'(c1) == fc};
  logic [3:0] m_abcd, m_fec;
  logic [4:0] m_err;
  logic       m_busy, m_done, m_pass, m_fev;
  assign m_abcd = sel ? c1 : c0;
  assign m_busy = sel ? b1.busy : b0.busy;
  assign m_done = sel ? b1.done : b0.done;
  assign m_pass = sel ? b1.pass : b0.pass;
  assign m_err  = sel ? b1.err_cnt : b0.err_cnt;
  assign m_fev  = sel ? b1.first_err_valid : b0.first_err_valid;
  assign m_fec  = sel ? b1.first_err_code : b0.first_err_code;
  int n_vec = 0, n_bad = 0;
  typedef struct {
    logic [3:0] s0, s1;
    int         fc;
    int         e, fec;
    bit         fev, pass;
  } vec_t;
  vec_t tbl[6];
  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic void ref_sweep(input logic [3:0] fs0, input logic [3:0] fs1, input int ffc,
                                    input int last, output int e, output int fec, output bit fev);
    e = 0; fec = 0; fev = 0;
    for (int c = 0; c <= last; c++) begin
      int good, got;
      good = (c + 3) % 16;
      got  = 0;
      for (int bt = 0; bt < 4; bt++) begin
        int v;
        v = fs0[bt] ? 0 : (good >> bt) & 1;
        if (fs1[bt]) v = 1;
        got += v << bt;
      end
      if (c == ffc) got = got ^ 1;
      if (got != good) begin
        e++;
        if (!fev) begin fev = 1; fec = c; end
      end
    end
  endfunction
  task automatic run_sweep(input int last, input int st, input int e, input int fec, input bit fev, input bit ps);
    bit ok;
    int per;
    ok = 1;
    per = st + 1;
    start_v = 1;
    tick();
    start_v = 0;
    for (int i = 0; i < (last + 1) * per; i++) begin
      if (!m_busy || m_done || m_abcd != 4'(i / per)) ok = 0;
      tick();
    end
    chk("code_sequence", ok, 1);
    chk("done_at_end", m_done, 1);
    chk("busy_drops", m_busy, 0);
    chk("err_cnt", m_err, e);
    chk("first_err_valid", m_fev, fev);
    chk("first_err_code", m_fec, fec);
    chk("pass", m_pass, ps);
    tick();
    chk("done_one_cycle", m_done, 0);
    chk("pass_stable", m_pass, ps);
    chk("err_cnt_stable", m_err, e);
  endtask
  initial begin
    int e, fec;
    bit fev, ok;
    tbl[0] = '{4'b0000, 4'b0000, 16, 0, 0, 0, 1};
    tbl[1] = '{4'b1000, 4'b0000, 16, 5, 5, 1, 0};
    tbl[2] = '{4'b0000, 4'b0001, 16, 5, 1, 1, 0};
    tbl[3] = '{4'b0000, 4'b0000, 7, 1, 7, 1, 0};
    tbl[4] = '{4'b0010, 4'b0000, 16, 5, 0, 1, 0};
    tbl[5] = '{4'b0000, 4'b1111, 16, 10, 0, 1, 0};
    #1;
    chk("rst_busy", m_busy, 0);
    chk("rst_done", m_done, 0);
    chk("rst_abcd", m_abcd, 0);
    chk("rst_pass", m_pass, 0);
    chk("rst_err_cnt", m_err, 0);
    chk("rst_fev", m_fev, 0);
    chk("rst_fec", m_fec, 0);
    tick();
    rst_n = 1;
    tick();
    foreach (tbl[i]) begin
      s0 = tbl[i].s0; s1 = tbl[i].s1; fc = tbl[i].fc;
      run_sweep(9, 2, tbl[i].e, tbl[i].fec, tbl[i].fev, tbl[i].pass);
    end
    for (int r = 0; r < 10; r++) begin
      s0 = 4'($urandom & $urandom);
      s1 = 4'($urandom & $urandom & $urandom);
      fc = $urandom_range(0, 16);
      ref_sweep(s0, s1, fc, 9, e, fec, fev);
      run_sweep(9, 2, e, fec, fev, e == 0);
    end
    s0 = 0; s1 = 0; fc = 16;
    start_v = 1;
    tick();
    start_v = 0;
    repeat (12) tick();
    chk("abort_pre_code", m_abcd, 4);
    abort_v = 1;
    tick();
    abort_v = 0;
    chk("abort_busy", m_busy, 0);
    chk("abort_abcd", m_abcd, 0);
    chk("abort_pass", m_pass, 0);
    ok = 1;
    repeat (6) begin
      if (m_done || m_busy) ok = 0;
      tick();
    end
    chk("abort_quiet", ok, 1);
    run_sweep(9, 2, 0, 0, 0, 1);
    fc = 2;
    start_v = 1;
    tick();
    start_v = 0;
    repeat (8) tick();
    abort_v = 1;
    tick();
    abort_v = 0;
    chk("abort_sample_err", m_err, 0);
    chk("abort_sample_fev", m_fev, 0);
    fc = 16;
    start_v = 1; abort_v = 1;
    tick();
    start_v = 0; abort_v = 0;
    chk("start_abort_idle", m_busy, 0);
    s0 = 4'b1000;
    start_v = 1;
    tick();
    ok = 1;
    repeat (30) begin
      if (m_done) ok = 0;
      tick();
    end
    chk("held_no_early_done", ok, 1);
    chk("held_done", m_done, 1);
    chk("held_err_cnt", m_err, 5);
    tick();
    chk("held_gap_busy", m_busy, 0);
    chk("held_gap_done", m_done, 0);
    tick();
    chk("held_restart_busy", m_busy, 1);
    chk("held_restart_err", m_err, 0);
    start_v = 0; abort_v = 1;
    tick();
    abort_v = 0; s0 = 0;
    s1 = 4'b1111;
    start_v = 1;
    tick();
    start_v = 0;
    repeat (7) tick();
    chk("pre_reset_err", m_err, 2);
    #3 rst_n = 0;
    #1;
    chk("async_rst_busy", m_busy, 0);
    chk("async_rst_abcd", m_abcd, 0);
    chk("async_rst_err", m_err, 0);
    chk("async_rst_fev", m_fev, 0);
    chk("async_rst_fec", m_fec, 0);
    tick();
    rst_n = 1;
    s1 = 0;
    ok = 1;
    repeat (6) begin
      if (m_busy || m_done || m_abcd != 0) ok = 0;
      tick();
    end
    chk("idle_after_reset", ok, 1);
    run_sweep(9, 2, 0, 0, 0, 1);
    #3 rst_n = 0;
    #1;
    chk("async_rst_pass", m_pass, 0);
    tick();
    rst_n = 1;
    tick();
    sel = 1;
    run_sweep(15, 1, 0, 0, 0, 1);
    s0 = 4'b1000;
    run_sweep(15, 1, 8, 5, 1, 0);
    s0 = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
